uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clocks per serial bit (25 MHz / 115200); legal range 8..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame; legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only when UART_RX_PARITY_EN is defined.
REQ-005 SHALL have port i_Clock  input  1  the single system clock; all logic on its rising edge.
REQ-006 SHALL have port i_Rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_RX_Serial  input  1  asynchronous serial line; idle high.
REQ-008 SHALL have port o_RX_DV  output  1  one-cycle pulse marking a completed frame.
REQ-009 SHALL have port o_RX_Byte  output  DATA_BITS  last received data word, LSB first on the line.
REQ-010 SHALL have port o_Frame_Err  output  1  stop bit sampled low; valid with o_RX_DV.
REQ-011 SHALL have port o_Parity_Err  output  1  parity mismatch; valid with o_RX_DV; tied 0 when parity is compiled out.
REQ-012 SHALL have port o_Break  output  1  all data bits and first stop bit low; valid with o_RX_DV.

Function
REQ-013 SHALL pass i_RX_Serial through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
REQ-015 IDLE: a synchronised low SHALL enter START with the bit counter at 0.
REQ-016 START: at count (CLKS_PER_BIT-1)/2 the line SHALL be resampled; low -> DATA with counter 0, high -> IDLE (glitch rejected, no outputs change).
REQ-017 DATA: every CLKS_PER_BIT clocks SHALL sample one bit into index 0..DATA_BITS-1, LSB first; after the last bit go to PARITY if compiled in, else STOP.
REQ-018 STOP: SHALL sample STOP_BITS bits at one-bit spacing; any low sample sets the frame error flag; after the last sample go to CLEANUP.
REQ-019 CLEANUP: lasts exactly one clock; o_RX_DV=1, o_RX_Byte and all error flags update in the same cycle; next state is WAIT_HIGH if the last stop sample was low, else IDLE.
REQ-020 WAIT_HIGH: SHALL stay until the synchronised line is high, then IDLE; no new start is detected while in this state.
REQ-021 Latency: o_RX_DV SHALL rise exactly one clock after the final stop-bit sample.
REQ-022 o_RX_Byte and error flags SHALL hold their values between pulses; o_RX_DV is 0 in every other state.
REQ-023 o_Break SHALL imply o_Frame_Err in the same pulse.
REQ-024 Bit counter width SHALL be $clog2(CLKS_PER_BIT) and SHALL never wrap within a bit.

Reset
REQ-025 On i_Rst_n low, state SHALL be IDLE, counters 0, synchroniser flops 1, and o_RX_DV, o_RX_Byte, o_Frame_Err, o_Parity_Err, o_Break all 0.
REQ-026 Reset mid-frame SHALL discard the partial frame and SHALL produce no o_RX_DV pulse.
REQ-027 After release, the first frame SHALL be received correctly provided its start edge comes at least 2 clocks after release.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample one bit after the data bits and set o_Parity_Err when the XOR of data and parity does not equal PARITY_ODD.
REQ-029 Without UART_RX_PARITY_EN, the PARITY state and its logic SHALL be absent; DATA goes directly to STOP; o_Parity_Err is constant 0.

Structure
REQ-030 Package uart_pkg SHALL hold the state enumeration and default constants (CLKS_PER_BIT_DEFAULT=217, DATA_BITS_DEFAULT=8).
REQ-031 Sub-module uart_rx_bit_timer SHALL hold the per-bit counter: load/half/full-bit strobes.

Verification (CLKS_PER_BIT=217, 40 ns clock, bit 8680 ns)
REQ-032 Send 8'hFF and 8'hA5 back-to-back, 8N1 -> two o_RX_DV pulses, bytes FF then A5, no error flags.
REQ-033 Line low for 3000 ns, then high -> START aborts, no o_RX_DV, o_RX_Byte unchanged.
REQ-034 Send 8'h3C with stop bit low, then line high -> o_RX_DV with o_Frame_Err=1, o_Break=0; next frame 8'h55 received clean.
REQ-035 Line held low 12 bit times -> one pulse, o_RX_Byte=0, o_Break=1, o_Frame_Err=1; no further pulse until line high and a new start.
REQ-036 With UART_RX_PARITY_EN, PARITY_ODD=0: send 8'h07 with parity 1 -> no error; with parity 0 -> o_Parity_Err=1.
REQ-037 Assert i_Rst_n low during data bit 4 of a frame -> no o_RX_DV, all outputs 0; after release, 8'h81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver.
// UART_RX_PARITY_EN adds the parity state to the enumeration.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;
    localparam int unsigned DATA_BITS_DEFAULT    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StCleanup,
        StWaitHigh
    } rx_state_e;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Per-bit counter for the UART receiver: free-runs while enabled, wraps once per bit,
// and strobes at the mid-point and at the last clock of a bit period.
module uart_rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic half,
    output logic full
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    assign half = run && (cnt_q == HalfCnt);
    assign full = run && (cnt_q == FullCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= full ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with frame, break and optional parity checking.
// Define UART_RX_PARITY_EN to compile in the parity bit and its check.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int unsigned STOP_BITS    = 1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Frame_Err,
    output logic                 o_Parity_Err,
    output logic                 o_Break
);

    localparam int unsigned IdxW = $clog2(DATA_BITS);

    logic [1:0]           sync_q;
    logic                 rx;
    rx_state_e            state_q;
    logic [IdxW-1:0]      bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 frame_acc_q;
    logic                 first_low_q;
    logic                 last_low_q;
    logic                 dv_q;
    logic [DATA_BITS-1:0] byte_q;
    logic                 frame_err_q;
    logic                 break_q;
    logic                 timer_load;
    logic                 timer_run;
    logic                 half;
    logic                 full;
    logic                 stop_low;
    logic                 first_low;
    logic                 last_stop;

    assign rx          = sync_q[1];
    assign o_RX_DV     = dv_q;
    assign o_RX_Byte   = byte_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Break     = break_q;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_RX_Serial};
        end
    end

    always_comb begin
        timer_run = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
`ifdef UART_RX_PARITY_EN
        timer_run = timer_run || (state_q == StParity);
`endif
        // Re-align the bit grid on the mid-point of the start bit.
        timer_load = !timer_run || ((state_q == StStart) && half);
        stop_low   = !rx;
        first_low  = (stop_idx_q == 1'b0) ? stop_low : first_low_q;
        last_stop  = (stop_idx_q == 1'(STOP_BITS - 1));
    end

    uart_rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (i_Clock),
        .rst_n(i_Rst_n),
        .load (timer_load),
        .run  (timer_run),
        .half (half),
        .full (full)
    );

`ifdef UART_RX_PARITY_EN
    logic par_acc_q;
    logic par_bad_q;
    logic parity_err_q;

    assign o_Parity_Err = parity_err_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            par_acc_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if ((state_q == StStart) && half) begin
                par_acc_q <= 1'b0;
            end else if ((state_q == StData) && full) begin
                par_acc_q <= par_acc_q ^ rx;
            end
            if ((state_q == StParity) && full) begin
                par_bad_q <= ((par_acc_q ^ rx) != PARITY_ODD);
            end
            if ((state_q == StStop) && full && last_stop) begin
                parity_err_q <= par_bad_q;
            end
        end
    end
`else
    assign o_Parity_Err = 1'b0;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= StIdle;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            data_q      <= '0;
            frame_acc_q <= 1'b0;
            first_low_q <= 1'b0;
            last_low_q  <= 1'b0;
            dv_q        <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rx) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (half) begin
                        bit_idx_q <= '0;
                        state_q   <= rx ? StIdle : StData;
                    end
                end
                StData: begin
                    if (full) begin
                        data_q[bit_idx_q] <= rx;
                        if (bit_idx_q == IdxW'(DATA_BITS - 1)) begin
                            bit_idx_q   <= '0;
                            stop_idx_q  <= 1'b0;
                            frame_acc_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_q     <= StParity;
`else
                            state_q     <= StStop;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + IdxW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (full) begin
                        state_q <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (full) begin
                        frame_acc_q <= frame_acc_q | stop_low;
                        first_low_q <= first_low;
                        stop_idx_q  <= stop_idx_q + 1'b1;
                        if (last_stop) begin
                            state_q     <= StCleanup;
                            dv_q        <= 1'b1;
                            byte_q      <= data_q;
                            frame_err_q <= frame_acc_q | stop_low;
                            break_q     <= (data_q == '0) && first_low;
                            last_low_q  <= stop_low;
                        end
                    end
                end
                StCleanup: begin
                    state_q <= last_low_q ? StWaitHigh : StIdle;
                end
                StWaitHigh: begin
                    if (rx) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
